conv_avalon_arbiter: RTL and testbench

- Round-robin arbiter that shares one Avalon-MM master port (toward the private-memory interconnect) among NUM_CORES convolution-core write masters.
- Each core's CoreWriteMaster-side Avalon signals (addr/read/write/byteenable/writedata/lock/waitreq) connect to one slot.
- Honours AvalonLock so a core's read-modify-write accumulate sequence is never interleaved with another core's transfer.
- Sits between the ConvCore array and the fabric/SDRAM bridge.

---
 rtl/conv_arb_pkg.sv | 39 +++
 rtl/conv_rr_picker.sv | 35 +++
 rtl/conv_avalon_arbiter.sv | 179 +++++++++++++++++
 tb/tb_conv_avalon_arbiter.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_arb_pkg.sv
// Shared types and helpers for the convolution-core Avalon arbiter.
// The round-robin pick is also used by the ShareLine broadcast scheduler.
package conv_arb_pkg;

  localparam int unsigned DEF_ADDR_W = 64;
  localparam int unsigned DEF_DATA_W = 512;
  localparam int unsigned MAX_CORES  = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    OWN    = 2'd1,
    LOCKED = 2'd2
  } arb_state_t;

  // Returns a one-hot grant for the first requester after ptr, wrapping modulo n.
  // The core at ptr itself is scanned last.
  function automatic logic [MAX_CORES-1:0] rr_pick(
    input logic [MAX_CORES-1:0] req,
    input int unsigned          ptr,
    input int unsigned          n
  );
    logic [MAX_CORES-1:0] g;
    logic                 found;
    int unsigned          idx;
    g     = '0;
    found = 1'b0;
    for (int unsigned i = 1; i <= MAX_CORES; i++) begin
      if (i <= n) begin
        idx = (ptr + i) % n;
        if (!found && req[idx[2:0]]) begin
          g[idx[2:0]] = 1'b1;
          found       = 1'b1;
        end
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/conv_rr_picker.sv
// Combinational round-robin priority encoder: request vector and last-served
// pointer in, one-hot grant, grant index and valid out.
module conv_rr_picker
  import conv_arb_pkg::*;
#(
  parameter int unsigned N     = 4,
  parameter int unsigned IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [N-1:0]     o_onehot,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_valid
);

  logic [MAX_CORES-1:0] w_req_ext;
  logic [MAX_CORES-1:0] w_pick;

  always_comb begin
    w_req_ext        = '0;
    w_req_ext[N-1:0] = i_req;
  end

  assign w_pick   = rr_pick(w_req_ext, 32'(i_ptr), N);
  assign o_onehot = w_pick[N-1:0];
  assign o_valid  = |w_pick;

  always_comb begin
    o_idx = '0;
    for (int k = 0; k < int'(N); k++) begin
      if (w_pick[k]) o_idx = IDX_W'(k);
    end
  end

endmodule

// File: rtl/conv_avalon_arbiter.sv
// Round-robin, lock-aware arbiter sharing one Avalon-MM master among the ConvCore
// write masters. Optional idle-lock timeout is enabled by `define ARB_LOCK_TIMEOUT_EN.
module conv_avalon_arbiter
  import conv_arb_pkg::*;
#(
  parameter int unsigned NUM_CORES    = 4,
  parameter int unsigned ADDR_W       = DEF_ADDR_W,
  parameter int unsigned DATA_W       = DEF_DATA_W,
  parameter int unsigned LOCK_TIMEOUT = 1024
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_CORES*ADDR_W-1:0]   CoreAddr_i,
  input  logic [NUM_CORES-1:0]          CoreRead_i,
  input  logic [NUM_CORES-1:0]          CoreWrite_i,
  input  logic [NUM_CORES*DATA_W/8-1:0] CoreByteEnable_i,
  input  logic [NUM_CORES*DATA_W-1:0]   CoreWriteData_i,
  input  logic [NUM_CORES-1:0]          CoreLock_i,
  output logic [NUM_CORES-1:0]          CoreWaitReq_o,
  output logic [DATA_W-1:0]             CoreReadData_o,
  output logic [ADDR_W-1:0]             AvalonAddr_o,
  output logic                          AvalonRead_o,
  output logic                          AvalonWrite_o,
  output logic [DATA_W/8-1:0]           AvalonByteEnable_o,
  output logic [DATA_W-1:0]             AvalonWriteData_o,
  output logic                          AvalonLock_o,
  input  logic                          AvalonWaitReq_i,
  input  logic [DATA_W-1:0]             AvalonReadData_i,
  output logic [NUM_CORES-1:0]          Grant_o,
  output logic                          LockTimeout_o
);

  // state  | meaning
  // IDLE   | no owner; pick next requester (master port idle this cycle)
  // OWN    | owner forwarded until its first accepted transfer
  // LOCKED | owner holds the port across a locked sequence

  localparam int unsigned PTR_W = $clog2(NUM_CORES);
  localparam int unsigned BE_W  = DATA_W / 8;

  arb_state_t             r_state, w_state_n;
  logic [NUM_CORES-1:0]   r_grant, w_grant_n;
  logic [PTR_W-1:0]       r_owner, w_owner_n;
  logic [PTR_W-1:0]       r_ptr, w_ptr_n;

  logic [NUM_CORES-1:0]   w_req;
  logic [NUM_CORES-1:0]   w_pick;
  logic [PTR_W-1:0]       w_pick_idx;
  logic                   w_pick_valid;
  logic                   w_owner_req;
  logic                   w_owner_lock;
  logic                   w_accept;

  assign w_req        = CoreRead_i | CoreWrite_i;
  assign w_owner_req  = w_req[r_owner];
  assign w_owner_lock = CoreLock_i[r_owner];
  assign w_accept     = (AvalonRead_o | AvalonWrite_o) & ~AvalonWaitReq_i;

  conv_rr_picker #(
    .N     (NUM_CORES),
    .IDX_W (PTR_W)
  ) u_picker (
    .i_req    (w_req),
    .i_ptr    (r_ptr),
    .o_onehot (w_pick),
    .o_idx    (w_pick_idx),
    .o_valid  (w_pick_valid)
  );

  // Grant is one-hot or zero, so an AND-OR mux yields all-zero outputs when idle.
  always_comb begin
    AvalonAddr_o       = '0;
    AvalonRead_o       = 1'b0;
    AvalonWrite_o      = 1'b0;
    AvalonByteEnable_o = '0;
    AvalonWriteData_o  = '0;
    AvalonLock_o       = 1'b0;
    CoreWaitReq_o      = '1;
    for (int k = 0; k < int'(NUM_CORES); k++) begin
      if (r_grant[k]) begin
        AvalonAddr_o       |= CoreAddr_i[k*ADDR_W +: ADDR_W];
        AvalonRead_o       |= CoreRead_i[k];
        AvalonWrite_o      |= CoreWrite_i[k];
        AvalonByteEnable_o |= CoreByteEnable_i[k*BE_W +: BE_W];
        AvalonWriteData_o  |= CoreWriteData_i[k*DATA_W +: DATA_W];
        AvalonLock_o       |= CoreLock_i[k];
        CoreWaitReq_o[k]    = AvalonWaitReq_i;
      end
    end
  end

  assign CoreReadData_o = AvalonReadData_i;
  assign Grant_o        = r_grant;

`ifdef ARB_LOCK_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(LOCK_TIMEOUT + 1);
  logic [CNT_W-1:0] r_idle_cnt, w_idle_cnt_n;
  logic             r_lock_timeout, w_lock_timeout_n;
  assign LockTimeout_o = r_lock_timeout;
`else
  assign LockTimeout_o = 1'b0;
`endif

  always_comb begin
    w_state_n = r_state;
    w_grant_n = r_grant;
    w_owner_n = r_owner;
    w_ptr_n   = r_ptr;
`ifdef ARB_LOCK_TIMEOUT_EN
    w_idle_cnt_n     = '0;
    w_lock_timeout_n = 1'b0;
`endif
    case (r_state)
      IDLE: begin
        if (w_pick_valid) begin
          w_grant_n = w_pick;
          w_owner_n = w_pick_idx;
          w_state_n = OWN;
        end
      end
      OWN: begin
        // A dropped request while waiting is a protocol violation; just let go.
        if (w_accept && w_owner_lock) begin
          w_state_n = LOCKED;
        end else if (w_accept || !w_owner_req) begin
          w_state_n = IDLE;
          w_grant_n = '0;
          w_ptr_n   = r_owner;
        end
      end
      LOCKED: begin
        if ((w_accept || !w_owner_req) && !w_owner_lock) begin
          w_state_n = IDLE;
          w_grant_n = '0;
          w_ptr_n   = r_owner;
        end
`ifdef ARB_LOCK_TIMEOUT_EN
        else if (!w_owner_req) begin
          if (r_idle_cnt == CNT_W'(LOCK_TIMEOUT - 1)) begin
            w_state_n        = IDLE;
            w_grant_n        = '0;
            w_ptr_n          = r_owner;
            w_lock_timeout_n = 1'b1;
          end else begin
            w_idle_cnt_n = r_idle_cnt + 1'b1;
          end
        end
`endif
      end
      default: begin
        w_state_n = IDLE;
        w_grant_n = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_grant <= '0;
      r_owner <= '0;
      r_ptr   <= PTR_W'(NUM_CORES - 1);
`ifdef ARB_LOCK_TIMEOUT_EN
      r_idle_cnt     <= '0;
      r_lock_timeout <= 1'b0;
`endif
    end else begin
      r_state <= w_state_n;
      r_grant <= w_grant_n;
      r_owner <= w_owner_n;
      r_ptr   <= w_ptr_n;
`ifdef ARB_LOCK_TIMEOUT_EN
      r_idle_cnt     <= w_idle_cnt_n;
      r_lock_timeout <= w_lock_timeout_n;
`endif
    end
  end

endmodule

// File: tb/tb_conv_avalon_arbiter.sv
// Directed test of conv_avalon_arbiter: arbitration latency, round-robin order,
// lock holding, waitrequest stretching, reset mid-transfer and lock release.
module tb_conv_avalon_arbiter;

  localparam int NUM_CORES = 4;
  localparam int ADDR_W    = 64;
  localparam int DATA_W    = 512;
  localparam int BE_W      = DATA_W / 8;

  logic                          clk = 1'b0;
  logic                          rst;
  logic [NUM_CORES*ADDR_W-1:0]   CoreAddr_i;
  logic [NUM_CORES-1:0]          CoreRead_i;
  logic [NUM_CORES-1:0]          CoreWrite_i;
  logic [NUM_CORES*BE_W-1:0]     CoreByteEnable_i;
  logic [NUM_CORES*DATA_W-1:0]   CoreWriteData_i;
  logic [NUM_CORES-1:0]          CoreLock_i;
  logic [NUM_CORES-1:0]          CoreWaitReq_o;
  logic [DATA_W-1:0]             CoreReadData_o;
  logic [ADDR_W-1:0]             AvalonAddr_o;
  logic                          AvalonRead_o;
  logic                          AvalonWrite_o;
  logic [BE_W-1:0]               AvalonByteEnable_o;
  logic [DATA_W-1:0]             AvalonWriteData_o;
  logic                          AvalonLock_o;
  logic                          AvalonWaitReq_i;
  logic [DATA_W-1:0]             AvalonReadData_i;
  logic [NUM_CORES-1:0]          Grant_o;
  logic                          LockTimeout_o;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  conv_avalon_arbiter #(
    .NUM_CORES    (NUM_CORES),
    .ADDR_W       (ADDR_W),
    .DATA_W       (DATA_W),
    .LOCK_TIMEOUT (8)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .CoreAddr_i         (CoreAddr_i),
    .CoreRead_i         (CoreRead_i),
    .CoreWrite_i        (CoreWrite_i),
    .CoreByteEnable_i   (CoreByteEnable_i),
    .CoreWriteData_i    (CoreWriteData_i),
    .CoreLock_i         (CoreLock_i),
    .CoreWaitReq_o      (CoreWaitReq_o),
    .CoreReadData_o     (CoreReadData_o),
    .AvalonAddr_o       (AvalonAddr_o),
    .AvalonRead_o       (AvalonRead_o),
    .AvalonWrite_o      (AvalonWrite_o),
    .AvalonByteEnable_o (AvalonByteEnable_o),
    .AvalonWriteData_o  (AvalonWriteData_o),
    .AvalonLock_o       (AvalonLock_o),
    .AvalonWaitReq_i    (AvalonWaitReq_i),
    .AvalonReadData_i   (AvalonReadData_i),
    .Grant_o            (Grant_o),
    .LockTimeout_o      (LockTimeout_o)
  );

  function automatic logic [DATA_W-1:0] core_data(input int k);
    logic [31:0] w;
    w = 32'hD00D_0000 | 32'(k);
    return {(DATA_W/32){w}};
  endfunction

  function automatic logic [ADDR_W-1:0] core_addr(input int k);
    return 64'h0000_1000_0000_0000 + 64'(k) * 64'h40;
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_core(input int k, input logic rd, input logic wr, input logic lk);
    CoreRead_i[k]  = rd;
    CoreWrite_i[k] = wr;
    CoreLock_i[k]  = lk;
  endtask

  task automatic clear_all();
    CoreRead_i  = '0;
    CoreWrite_i = '0;
    CoreLock_i  = '0;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    clear_all();
    AvalonWaitReq_i  = 1'b0;
    AvalonReadData_i = '0;
    for (int k = 0; k < NUM_CORES; k++) begin
      CoreAddr_i[k*ADDR_W +: ADDR_W]      = core_addr(k);
      CoreWriteData_i[k*DATA_W +: DATA_W] = core_data(k);
      CoreByteEnable_i[k*BE_W +: BE_W]    = '1;
    end
    pulse_reset();
    #1;
    n_vec++; if (Grant_o !== 4'b0000) begin n_err++; $display("FAIL reset_grant: got %b want 0000", Grant_o); end
    n_vec++; if (CoreWaitReq_o !== 4'b1111) begin n_err++; $display("FAIL reset_waitreq: got %b want 1111", CoreWaitReq_o); end
    n_vec++; if ({AvalonRead_o, AvalonWrite_o, AvalonLock_o, LockTimeout_o} !== 4'b0000) begin n_err++; $display("FAIL reset_ctrl: got %b want 0000", {AvalonRead_o, AvalonWrite_o, AvalonLock_o, LockTimeout_o}); end
    n_vec++; if (AvalonAddr_o !== '0 || AvalonByteEnable_o !== '0) begin n_err++; $display("FAIL reset_addr_be: got %h want 0", AvalonAddr_o); end
  endtask

  task automatic test_single_write();
    set_core(2, 1'b0, 1'b1, 1'b0);
    #1;
    n_vec++; if (Grant_o !== 4'b0000 || AvalonWrite_o !== 1'b0) begin n_err++; $display("FAIL single_arb_cycle: grant %b write %b want 0000 0", Grant_o, AvalonWrite_o); end
    tick();
    n_vec++; if (Grant_o !== 4'b0100) begin n_err++; $display("FAIL single_grant: got %b want 0100", Grant_o); end
    n_vec++; if (AvalonWrite_o !== 1'b1 || AvalonAddr_o !== core_addr(2)) begin n_err++; $display("FAIL single_addr: got %b %h want 1 %h", AvalonWrite_o, AvalonAddr_o, core_addr(2)); end
    n_vec++; if (AvalonWriteData_o !== core_data(2)) begin n_err++; $display("FAIL single_data: got %h want %h", AvalonWriteData_o[31:0], 32'hD00D_0002); end
    n_vec++; if (CoreWaitReq_o !== 4'b1011) begin n_err++; $display("FAIL single_waitreq: got %b want 1011", CoreWaitReq_o); end
    tick();
    set_core(2, 1'b0, 1'b0, 1'b0);
    #1;
    n_vec++; if (Grant_o !== 4'b0000 || AvalonWrite_o !== 1'b0) begin n_err++; $display("FAIL single_release: grant %b write %b want 0000 0", Grant_o, AvalonWrite_o); end
  endtask

  task automatic test_round_robin();
    pulse_reset();
    CoreWrite_i = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      tick();
      n_vec++; if (Grant_o !== 4'(1 << (g % 4))) begin n_err++; $display("FAIL rr_grant%0d: got %b want %b", g, Grant_o, 4'(1 << (g % 4))); end
      n_vec++; if (AvalonWriteData_o !== core_data(g % 4)) begin n_err++; $display("FAIL rr_data%0d: got %h want %h", g, AvalonWriteData_o[31:0], 32'hD00D_0000 | 32'(g % 4)); end
      tick();
      n_vec++; if (Grant_o !== 4'b0000) begin n_err++; $display("FAIL rr_idle%0d: got %b want 0000", g, Grant_o); end
    end
    clear_all();
  endtask

  task automatic test_lock();
    // Pointer sits at core 0, so core 1 wins the simultaneous request.
    set_core(1, 1'b1, 1'b0, 1'b1);
    set_core(0, 1'b0, 1'b1, 1'b0);
    tick();
    n_vec++; if (Grant_o !== 4'b0010 || AvalonRead_o !== 1'b1 || AvalonLock_o !== 1'b1) begin n_err++; $display("FAIL lock_first: grant %b rd %b lk %b want 0010 1 1", Grant_o, AvalonRead_o, AvalonLock_o); end
    tick();
    set_core(1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      #1;
      n_vec++; if (Grant_o !== 4'b0010 || CoreWaitReq_o[0] !== 1'b1) begin n_err++; $display("FAIL lock_hold%0d: grant %b wr0 %b want 0010 1", i, Grant_o, CoreWaitReq_o[0]); end
      n_vec++; if (AvalonRead_o !== 1'b0 || AvalonWrite_o !== 1'b0) begin n_err++; $display("FAIL lock_idle_bus%0d: rd %b wr %b want 0 0", i, AvalonRead_o, AvalonWrite_o); end
      tick();
    end
    set_core(1, 1'b0, 1'b1, 1'b0);
    #1;
    n_vec++; if (AvalonWrite_o !== 1'b1 || AvalonLock_o !== 1'b0 || CoreWaitReq_o !== 4'b1101) begin n_err++; $display("FAIL lock_final_write: wr %b lk %b wait %b want 1 0 1101", AvalonWrite_o, AvalonLock_o, CoreWaitReq_o); end
    tick();
    set_core(1, 1'b0, 1'b0, 1'b0);
    #1;
    n_vec++; if (Grant_o !== 4'b0000 || CoreWaitReq_o[0] !== 1'b1) begin n_err++; $display("FAIL lock_release: grant %b wr0 %b want 0000 1", Grant_o, CoreWaitReq_o[0]); end
    tick();
    n_vec++; if (Grant_o !== 4'b0001 || CoreWaitReq_o[0] !== 1'b0) begin n_err++; $display("FAIL lock_next_owner: grant %b wr0 %b want 0001 0", Grant_o, CoreWaitReq_o[0]); end
    clear_all();
    tick();
  endtask

  task automatic test_waitreq_read();
    logic [DATA_W-1:0] rd_pat;
    rd_pat = {BE_W{8'hA5}};
    set_core(3, 1'b1, 1'b0, 1'b0);
    AvalonWaitReq_i = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      #1;
      n_vec++; if (Grant_o !== 4'b1000 || CoreWaitReq_o[3] !== 1'b1 || AvalonRead_o !== 1'b1) begin n_err++; $display("FAIL wait_stretch%0d: grant %b wr3 %b rd %b want 1000 1 1", i, Grant_o, CoreWaitReq_o[3], AvalonRead_o); end
      tick();
    end
    AvalonWaitReq_i  = 1'b0;
    AvalonReadData_i = rd_pat;
    #1;
    n_vec++; if (CoreWaitReq_o[3] !== 1'b0 || CoreReadData_o !== rd_pat) begin n_err++; $display("FAIL wait_accept: wr3 %b data %h want 0 a5a5a5a5", CoreWaitReq_o[3], CoreReadData_o[31:0]); end
    tick();
    clear_all();
    AvalonReadData_i = '0;
    #1;
    n_vec++; if (Grant_o !== 4'b0000) begin n_err++; $display("FAIL wait_release: got %b want 0000", Grant_o); end
  endtask

  task automatic test_reset_mid();
    set_core(0, 1'b0, 1'b1, 1'b0);
    tick();
    clear_all();
    tick();
    // Pointer now at core 0; core 2 takes the port and stalls.
    set_core(2, 1'b0, 1'b1, 1'b0);
    AvalonWaitReq_i = 1'b1;
    tick();
    n_vec++; if (Grant_o !== 4'b0100) begin n_err++; $display("FAIL rstmid_owner: got %b want 0100", Grant_o); end
    rst = 1'b1;
    tick();
    n_vec++; if (Grant_o !== 4'b0000 || AvalonWrite_o !== 1'b0 || AvalonAddr_o !== '0 || AvalonWriteData_o !== '0) begin n_err++; $display("FAIL rstmid_outputs: grant %b wr %b addr %h want 0000 0 0", Grant_o, AvalonWrite_o, AvalonAddr_o); end
    rst = 1'b0;
    clear_all();
    AvalonWaitReq_i = 1'b0;
    set_core(0, 1'b0, 1'b1, 1'b0);
    set_core(1, 1'b0, 1'b1, 1'b0);
    tick();
    n_vec++; if (Grant_o !== 4'b0001) begin n_err++; $display("FAIL rstmid_first_arb: got %b want 0001", Grant_o); end
    clear_all();
    tick();
  endtask

  task automatic test_drop_request();
    set_core(1, 1'b0, 1'b1, 1'b0);
    AvalonWaitReq_i = 1'b1;
    tick();
    n_vec++; if (Grant_o !== 4'b0010) begin n_err++; $display("FAIL drop_owner: got %b want 0010", Grant_o); end
    set_core(1, 1'b0, 1'b0, 1'b0);
    tick();
    n_vec++; if (Grant_o !== 4'b0000) begin n_err++; $display("FAIL drop_release: got %b want 0000", Grant_o); end
    AvalonWaitReq_i = 1'b0;
  endtask

  task automatic test_lock_idle();
    // Pointer at core 1 after the drop, so core 2 wins over core 0.
    set_core(2, 1'b1, 1'b0, 1'b1);
    set_core(0, 1'b0, 1'b1, 1'b0);
    tick();
    n_vec++; if (Grant_o !== 4'b0100) begin n_err++; $display("FAIL lkidle_owner: got %b want 0100", Grant_o); end
    tick();
    set_core(2, 1'b0, 1'b0, 1'b1);
`ifdef ARB_LOCK_TIMEOUT_EN
    for (int i = 0; i < 8; i++) begin
      #1;
      n_vec++; if (Grant_o !== 4'b0100 || LockTimeout_o !== 1'b0) begin n_err++; $display("FAIL lkto_hold%0d: grant %b to %b want 0100 0", i, Grant_o, LockTimeout_o); end
      tick();
    end
    n_vec++; if (Grant_o !== 4'b0000 || LockTimeout_o !== 1'b1) begin n_err++; $display("FAIL lkto_pulse: grant %b to %b want 0000 1", Grant_o, LockTimeout_o); end
    tick();
    n_vec++; if (Grant_o !== 4'b0001 || LockTimeout_o !== 1'b0) begin n_err++; $display("FAIL lkto_next: grant %b to %b want 0001 0", Grant_o, LockTimeout_o); end
`else
    for (int i = 0; i < 12; i++) begin
      #1;
      n_vec++; if (Grant_o !== 4'b0100 || LockTimeout_o !== 1'b0) begin n_err++; $display("FAIL lkhold%0d: grant %b to %b want 0100 0", i, Grant_o, LockTimeout_o); end
      tick();
    end
    set_core(2, 1'b0, 1'b0, 1'b0);
    tick();
    n_vec++; if (Grant_o !== 4'b0000) begin n_err++; $display("FAIL lkhold_release: got %b want 0000", Grant_o); end
    tick();
    n_vec++; if (Grant_o !== 4'b0001) begin n_err++; $display("FAIL lkhold_next: got %b want 0001", Grant_o); end
`endif
    clear_all();
    tick();
    tick();
  endtask

  initial begin
    rst              = 1'b1;
    CoreAddr_i       = '0;
    CoreWriteData_i  = '0;
    CoreByteEnable_i = '0;
    CoreRead_i       = '0;
    CoreWrite_i      = '0;
    CoreLock_i       = '0;
    AvalonWaitReq_i  = 1'b0;
    AvalonReadData_i = '0;
    test_reset();
    test_single_write();
    test_round_robin();
    test_lock();
    test_waitreq_read();
    test_reset_mid();
    test_drop_request();
    test_lock_idle();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
